// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dma_pkg
// Function : Shared DMA sizing constants and FIFO counter-width helper.
// Revision : 1.0
// ============================================================================
package dma_pkg;

    localparam int DMA_DATA_W     = 256;
    localparam int DMA_FIFO_DEPTH = 256;

    // usedw must represent 0..DEPTH inclusive, hence one bit beyond the index
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : dma_fifo_ram
// Function : Simple dual-port RAM, registered read, old data on collision.
// Revision : 1.0
// ============================================================================
module dma_fifo_ram #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_data_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : dma_data_fifo_fwft
// Function : DMA read->write data buffer with show-ahead or normal read mode.
// Revision : 1.0
// ============================================================================
module dma_data_fifo_fwft
    import dma_pkg::*;
#(
    parameter int DATA_W    = DMA_DATA_W,
    parameter int DEPTH     = DMA_FIFO_DEPTH,
    parameter bit SHOWAHEAD = 1'b1,
    parameter int AF_LEVEL  = DEPTH - 8,
    parameter int AE_LEVEL  = 2,
    parameter int CNT_W     = fifo_cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] dma_rd_data_i,
    input  logic              dma_rd_data_valid_i,
    output logic              dma_data_fifo_almost_full_o,
    output logic              dma_data_fifo_full_o,
    output logic [DATA_W-1:0] dma_data_o,
    output logic              dma_data_fifo_empty_o,
    output logic              dma_data_fifo_almost_empty_o,
    input  logic              dma_data_fifo_rd_req_i,
    output logic [CNT_W-1:0]  dma_data_fifo_usedw_o,
    input  logic              flush_i,
    input  logic              err_clr_i,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int               c_addr_w = CNT_W - 1;
    localparam logic [CNT_W-1:0] c_full   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_af     = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] c_ae     = CNT_W'(AE_LEVEL);

    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]    r_usedw;
    logic [CNT_W-1:0]    w_usedw_nxt;
    logic                r_af;
    logic                r_ae;
    logic                r_ovf;
    logic                r_unf;
    logic [DATA_W-1:0]   r_dout;
    logic [DATA_W-1:0]   w_ram_q;
    logic                w_full;
    logic                w_empty;
    logic                w_rd_acc;
    logic                w_wr_acc;
    logic                w_ram_rd;
    logic                w_ovf_set;
    logic                w_unf_set;

    assign w_full = (r_usedw == c_full);

    // flush wins over any same-cycle request and raises no error
    always_comb begin
        w_rd_acc    = dma_data_fifo_rd_req_i & ~w_empty & ~flush_i;
        w_wr_acc    = dma_rd_data_valid_i & (~w_full | w_rd_acc) & ~flush_i;
        w_ovf_set   = dma_rd_data_valid_i & ~w_wr_acc & ~flush_i;
        w_unf_set   = dma_data_fifo_rd_req_i & w_empty & ~flush_i;
        w_usedw_nxt = r_usedw;
        if (flush_i) begin
            w_usedw_nxt = '0;
        end else if (w_wr_acc && !w_rd_acc) begin
            w_usedw_nxt = r_usedw + 1'b1;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_usedw_nxt = r_usedw - 1'b1;
        end
    end

    generate
        if (SHOWAHEAD) begin : g_showahead
            logic             r_out_valid;
            logic             r_pend;
            logic [CNT_W-1:0] w_avail;

            // words still sitting in RAM, not yet fetched into the output stage
            assign w_avail  = r_usedw - CNT_W'(r_out_valid) - CNT_W'(r_pend);
            assign w_empty  = ~r_out_valid;
            assign w_ram_rd = ~flush_i & (w_avail != '0) &
                              ((~r_out_valid & ~r_pend) | w_rd_acc);

            always_ff @(posedge clk) begin
                if (!reset || flush_i) begin
                    r_out_valid <= 1'b0;
                    r_pend      <= 1'b0;
                    r_dout      <= '0;
                end else begin
                    r_pend <= w_ram_rd;
                    if (r_pend) begin
                        r_dout      <= w_ram_q;
                        r_out_valid <= 1'b1;
                    end else if (w_rd_acc) begin
                        r_out_valid <= 1'b0;
                    end
                end
            end
        end else begin : g_normal
            logic r_pend;

            assign w_empty  = (r_usedw == '0);
            assign w_ram_rd = w_rd_acc;

            always_ff @(posedge clk) begin
                if (!reset || flush_i) begin
                    r_pend <= 1'b0;
                    r_dout <= '0;
                end else begin
                    r_pend <= w_rd_acc;
                    if (r_pend) begin
                        r_dout <= w_ram_q;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usedw  <= '0;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_ram_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_usedw <= w_usedw_nxt;
            r_af    <= (w_usedw_nxt >= c_af);
            r_ae    <= (w_usedw_nxt <= c_ae);
            r_ovf   <= w_ovf_set | (r_ovf & ~err_clr_i);
            r_unf   <= w_unf_set | (r_unf & ~err_clr_i);
        end
    end

    dma_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (c_addr_w)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (dma_rd_data_i),
        .i_rd_en   (w_ram_rd),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_q)
    );

    assign dma_data_o                   = r_dout;
    assign dma_data_fifo_empty_o        = w_empty;
    assign dma_data_fifo_full_o         = w_full;
    assign dma_data_fifo_almost_full_o  = r_af;
    assign dma_data_fifo_almost_empty_o = r_ae;
    assign dma_data_fifo_usedw_o        = r_usedw;
    assign overflow_o                   = r_ovf;
    assign underflow_o                  = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_dma_data_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_data_fifo_fwft
// Function : Runs a show-ahead and a normal-mode FIFO side by side against a
//            queue/timestamp model. Revision : 1.0
// ============================================================================
module tb_dma_data_fifo_fwft;

    localparam int c_w     = 16;
    localparam int c_depth = 16;
    localparam int c_af    = 8;
    localparam int c_ae    = 2;
    localparam int c_cw    = 5;
    localparam int c_mlen  = 1024;

    logic clk;
    logic rst_n;
    logic [c_w-1:0] wr_data;
    logic wr_valid, rd_req, flush, err_clr;

    logic [c_w-1:0]  sa_dout, nm_dout;
    logic [c_cw-1:0] sa_usedw, nm_usedw;
    logic sa_af, sa_full, sa_empty, sa_ae, sa_ovf, sa_unf;
    logic nm_af, nm_full, nm_empty, nm_ae, nm_ovf, nm_unf;

    int n_cmp = 0;
    int n_err = 0;

    // model: index 0 = show-ahead, 1 = normal; entries never recycled
    logic [c_w-1:0] md  [0:1][0:c_mlen-1];
    int             mwt [0:1][0:c_mlen-1];
    int             head [0:1];
    int             tail [0:1];
    int             last_pop [0:1];
    bit             movf [0:1];
    bit             munf [0:1];
    logic [c_w-1:0] nout [0:1];
    logic [c_w-1:0] pdata [0:1];
    bit             npend [0:1];
    int             ecnt = 0;

    dma_data_fifo_fwft #(.DATA_W(c_w), .DEPTH(c_depth), .SHOWAHEAD(1'b1),
                         .AF_LEVEL(c_af), .AE_LEVEL(c_ae)) dut_sa (
        .clk(clk), .reset(rst_n),
        .dma_rd_data_i(wr_data), .dma_rd_data_valid_i(wr_valid),
        .dma_data_fifo_almost_full_o(sa_af), .dma_data_fifo_full_o(sa_full),
        .dma_data_o(sa_dout), .dma_data_fifo_empty_o(sa_empty),
        .dma_data_fifo_almost_empty_o(sa_ae), .dma_data_fifo_rd_req_i(rd_req),
        .dma_data_fifo_usedw_o(sa_usedw), .flush_i(flush), .err_clr_i(err_clr),
        .overflow_o(sa_ovf), .underflow_o(sa_unf));

    dma_data_fifo_fwft #(.DATA_W(c_w), .DEPTH(c_depth), .SHOWAHEAD(1'b0),
                         .AF_LEVEL(c_af), .AE_LEVEL(c_ae)) dut_nm (
        .clk(clk), .reset(rst_n),
        .dma_rd_data_i(wr_data), .dma_rd_data_valid_i(wr_valid),
        .dma_data_fifo_almost_full_o(nm_af), .dma_data_fifo_full_o(nm_full),
        .dma_data_o(nm_dout), .dma_data_fifo_empty_o(nm_empty),
        .dma_data_fifo_almost_empty_o(nm_ae), .dma_data_fifo_rd_req_i(rd_req),
        .dma_data_fifo_usedw_o(nm_usedw), .flush_i(flush), .err_clr_i(err_clr),
        .overflow_o(nm_ovf), .underflow_o(nm_unf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Show-ahead head is fetched one edge after it is both in RAM and the
    // previous head has left, and becomes visible one edge later.
    function automatic bit m_empty(input int m);
        int fetch;
        if (tail[m] == head[m]) return 1'b1;
        if (m == 1) return 1'b0;
        fetch = (mwt[m][head[m]] + 1 > last_pop[m]) ? mwt[m][head[m]] + 1 : last_pop[m];
        return (ecnt < fetch + 1);
    endfunction

    initial begin
        for (int m = 0; m < 2; m++) begin
            head[m] = 0; tail[m] = 0; last_pop[m] = 0; movf[m] = 0; munf[m] = 0;
            nout[m] = '0; pdata[m] = '0; npend[m] = 0;
        end
    end

    always @(posedge clk) begin
        bit emp, rda, wra, oset, uset;
        int e;
        e = ecnt + 1;
        for (int m = 0; m < 2; m++) begin
            oset = 0; uset = 0;
            if (!rst_n) begin
                head[m] = tail[m]; last_pop[m] = e; movf[m] = 0; munf[m] = 0;
                nout[m] = '0; npend[m] = 0;
            end else begin
                emp = m_empty(m);
                if (npend[m]) nout[m] = pdata[m];
                npend[m] = 0;
                if (flush) begin
                    head[m] = tail[m]; last_pop[m] = e; nout[m] = '0;
                end else begin
                    rda  = rd_req && !emp;
                    wra  = wr_valid && ((tail[m] - head[m]) < c_depth || rda);
                    oset = wr_valid && !wra;
                    uset = rd_req && emp;
                    if (rda) begin
                        pdata[m] = md[m][head[m]]; npend[m] = 1;
                        head[m]++; last_pop[m] = e;
                    end
                    if (wra && tail[m] < c_mlen) begin
                        md[m][tail[m]] = wr_data; mwt[m][tail[m]] = e; tail[m]++;
                    end
                end
                if (err_clr) begin movf[m] = 0; munf[m] = 0; end
                if (oset) movf[m] = 1;
                if (uset) munf[m] = 1;
            end
        end
        ecnt = e;
    end

    task automatic cmp_mode(input int m, input string t, input logic [c_w-1:0] dout,
                            input bit empty, input bit ae, input bit af, input bit full,
                            input logic [c_cw-1:0] usedw, input bit ovf, input bit unf);
        int c;
        bit me;
        c  = tail[m] - head[m];
        me = m_empty(m);
        chk({t, ".usedw"}, int'(usedw), c);
        chk({t, ".usedw_bound"}, int'(usedw <= c_cw'(c_depth)), 1);
        chk({t, ".full"}, int'(full), int'(c == c_depth));
        chk({t, ".almost_full"}, int'(af), int'(c >= c_af));
        chk({t, ".almost_empty"}, int'(ae), int'(c <= c_ae));
        chk({t, ".empty"}, int'(empty), int'(me));
        chk({t, ".overflow"}, int'(ovf), int'(movf[m]));
        chk({t, ".underflow"}, int'(unf), int'(munf[m]));
        if (m == 1) chk({t, ".dout"}, int'(dout), int'(nout[m]));
        else if (!me) chk({t, ".dout"}, int'(dout), int'(md[m][head[m]]));
    endtask

    always @(negedge clk) begin
        if (ecnt > 0) begin
            cmp_mode(0, "sa", sa_dout, sa_empty, sa_ae, sa_af, sa_full, sa_usedw, sa_ovf, sa_unf);
            cmp_mode(1, "nm", nm_dout, nm_empty, nm_ae, nm_af, nm_full, nm_usedw, nm_ovf, nm_unf);
        end
    end

    task automatic step(input bit wv, input logic [c_w-1:0] wd, input bit rd,
                        input bit fl = 1'b0, input bit ec = 1'b0);
        wr_valid = wv; wr_data = wd; rd_req = rd; flush = fl; err_clr = ec;
        @(posedge clk);
        #1;
        wr_valid = 1'b0; rd_req = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [c_w-1:0] pat;
        rst_n = 1'b0; wr_valid = 0; wr_data = '0; rd_req = 0; flush = 0; err_clr = 0;
        idle(2);
        rst_n = 1'b1;
        chk("rst.usedw", int'(sa_usedw), 0);
        chk("rst.sa_empty", int'(sa_empty), 1);
        chk("rst.nm_empty", int'(nm_empty), 1);
        chk("rst.almost_empty", int'(sa_ae), 1);
        chk("rst.full", int'(sa_full), 0);
        chk("rst.almost_full", int'(nm_af), 0);
        chk("rst.overflow", int'(sa_ovf), 0);
        chk("rst.underflow", int'(nm_unf), 0);
        chk("rst.sa_dout", int'(sa_dout), 0);
        chk("rst.nm_dout", int'(nm_dout), 0);

        // show-ahead first-word latency and pop cadence
        step(1, 16'h0001, 0);
        chk("t1.sa_empty_w1", int'(sa_empty), 1);
        chk("t1.nm_empty_w1", int'(nm_empty), 0);
        step(1, 16'h0002, 0);
        chk("t1.sa_empty_w2", int'(sa_empty), 1);
        step(1, 16'h0003, 0);
        chk("t1.sa_empty_w3", int'(sa_empty), 0);
        chk("t1.sa_head", int'(sa_dout), 16'h0001);
        chk("t1.usedw3", int'(sa_usedw), 3);
        step(0, '0, 1);
        chk("t1.sa_bubble", int'(sa_empty), 1);
        idle(1);
        chk("t1.sa_second", int'(sa_dout), 16'h0002);
        chk("t1.nm_first", int'(nm_dout), 16'h0001);
        step(0, '0, 1);
        idle(1);
        chk("t1.sa_third", int'(sa_dout), 16'h0003);
        chk("t1.nm_second", int'(nm_dout), 16'h0002);
        step(0, '0, 1);
        chk("t1.sa_empty_end", int'(sa_empty), 1);
        chk("t1.usedw_end", int'(sa_usedw), 0);
        idle(1);
        chk("t1.nm_third", int'(nm_dout), 16'h0003);

        // normal-mode read latency and underflow
        step(1, 16'h00A5, 0);
        idle(2);
        step(0, '0, 1);
        chk("t3.nm_before", int'(nm_dout), 16'h0003);
        idle(1);
        chk("t3.nm_a5", int'(nm_dout), 16'h00A5);
        step(0, '0, 1);
        chk("t3.nm_underflow", int'(nm_unf), 1);
        chk("t3.sa_underflow", int'(sa_unf), 1);
        chk("t3.nm_hold", int'(nm_dout), 16'h00A5);
        step(0, '0, 0, 0, 1);
        chk("t3.unf_clr", int'(nm_unf), 0);

        // fill, almost-full threshold, overflow, read+write at full
        for (int i = 0; i < c_depth; i++) begin
            step(1, 16'(16'h0010 + i), 0);
            if (i == c_af - 2) chk("t2.af_below", int'(sa_af), 0);
            if (i == c_af - 1) chk("t2.af_at", int'(nm_af), 1);
        end
        chk("t2.full", int'(sa_full), 1);
        step(1, 16'h0020, 0);
        chk("t2.overflow", int'(sa_ovf), 1);
        chk("t2.usedw16", int'(nm_usedw), 16);
        step(0, '0, 0, 0, 1);
        chk("t2.ovf_clr", int'(nm_ovf), 0);
        step(1, 16'h0021, 1);
        chk("t2.rw_full_ovf", int'(sa_ovf), 0);
        chk("t2.rw_full_usedw", int'(sa_usedw), 16);
        step(1, 16'h0022, 0, 0, 1);
        chk("t2.set_wins", int'(nm_ovf), 1);
        for (int i = 0; i < 18; i++) begin step(0, '0, 1); idle(1); end
        step(0, '0, 0, 0, 1);
        chk("t2.drained", int'(sa_usedw), 0);

        // random interleave across several pointer wraps
        pat = 16'h1000;
        for (int i = 0; i < 240; i++) begin
            bit wv, rd;
            wv = ($urandom_range(0, 9) < 6);
            rd = ($urandom_range(0, 9) < 5);
            step(wv, pat, rd);
            if (wv) pat = pat + 16'h1;
        end
        for (int i = 0; i < 18; i++) begin step(0, '0, 1); idle(1); end
        step(0, '0, 0, 1, 1);

        // reset mid-burst at usedw = 10
        for (int i = 0; i < 10; i++) step(1, 16'(16'h0040 + i), 0);
        chk("t5.usedw10", int'(nm_usedw), 10);
        rst_n = 1'b0;
        step(1, 16'h0099, 1);
        rst_n = 1'b1;
        chk("t5.usedw", int'(sa_usedw), 0);
        chk("t5.sa_empty", int'(sa_empty), 1);
        chk("t5.nm_empty", int'(nm_empty), 1);
        chk("t5.sa_dout", int'(sa_dout), 0);
        chk("t5.nm_dout", int'(nm_dout), 0);
        step(1, 16'h0077, 0);
        idle(2);
        chk("t5.sa_rt", int'(sa_dout), 16'h0077);
        step(0, '0, 1);
        idle(1);
        chk("t5.nm_rt", int'(nm_dout), 16'h0077);

        // flush with a same-cycle write at usedw = 5, overflow pending
        for (int i = 0; i < c_depth + 1; i++) step(1, 16'(16'h0050 + i), 0);
        for (int i = 0; i < 11; i++) begin step(0, '0, 1); idle(1); end
        chk("t6.usedw5", int'(sa_usedw), 5);
        step(1, 16'h00EE, 0, 1, 0);
        chk("t6.usedw0", int'(sa_usedw), 0);
        chk("t6.nm_usedw0", int'(nm_usedw), 0);
        chk("t6.sa_empty", int'(sa_empty), 1);
        chk("t6.nm_empty", int'(nm_empty), 1);
        chk("t6.sa_ovf", int'(sa_ovf), 1);
        chk("t6.nm_ovf", int'(nm_ovf), 1);
        step(1, 16'h0088, 0);
        idle(2);
        chk("t6.sa_after", int'(sa_dout), 16'h0088);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
